// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared core constants and fetch FSM encoding for the ifetch stage
package ifetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous instruction buffer, power-of-two DEPTH, flush clears all entries
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Empty buffer presents zeros so the stage outputs read 0 after reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage; IFETCH_PREFETCH_ABORT_EN adds i_imem_err/o_abort tracking
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_pc_adv,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
`ifdef IFETCH_PREFETCH_ABORT_EN
  input  logic            i_imem_err,
  output logic            o_abort,
`endif
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_ready
);

`ifdef IFETCH_PREFETCH_ABORT_EN
  localparam int ENTRY_W = 2*XLEN + 1;
`else
  localparam int ENTRY_W = 2*XLEN;
`endif

  fetch_state_e     state, state_nxt;
  logic [XLEN-1:0]  addr_q, addr_nxt;
  logic             issue;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ENTRY_W-1:0] entry_w;
  logic [ENTRY_W-1:0] entry_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    issue       = 1'b0;
    push        = 1'b0;
    o_imem_req  = 1'b0;
    o_imem_addr = addr_q;
    case (state)
      ST_IDLE: begin
        o_imem_addr = word_align(i_pc);
        if (en && !rst && !i_flush && !fifo_full) begin
          issue      = 1'b1;
          o_imem_req = 1'b1;
          addr_nxt   = word_align(i_pc);
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_imem_req = 1'b1;
        if (en) begin
          if (i_flush) begin
            state_nxt = i_imem_ack ? ST_IDLE : ST_DRAIN;
          end else if (i_imem_ack) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // The redirected-away response still has to be absorbed before reissuing.
        o_imem_req = 1'b1;
        if (en && i_imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_pc_adv = issue;
  assign o_valid  = !fifo_empty && !i_flush;
  assign pop      = o_valid && i_ready && en;

`ifdef IFETCH_PREFETCH_ABORT_EN
  assign entry_w = {i_imem_err, addr_q, i_imem_rdata};
  assign o_abort = entry_r[2*XLEN];
`else
  assign entry_w = {addr_q, i_imem_rdata};
`endif

  assign o_instr_pc = entry_r[2*XLEN-1:XLEN];
  assign o_instr    = entry_r[XLEN-1:0];

  ifetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (en && i_flush),
    .push  (push),
    .wdata (entry_w),
    .pop   (pop),
    .rdata (entry_r),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch against a queue-based fetch model
module tb_ifetch;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_pc_adv;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_imem_err;
  logic        o_abort;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_ready;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .o_pc_adv     (o_pc_adv),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
`ifdef IFETCH_PREFETCH_ABORT_EN
    .i_imem_err   (i_imem_err),
    .o_abort      (o_abort),
`endif
    .o_valid      (o_valid),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc),
    .i_ready      (i_ready)
  );

`ifndef IFETCH_PREFETCH_ABORT_EN
  assign o_abort = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        abort;
  } exp_t;

  exp_t        q[$];
  logic        outstanding;
  logic        drop;
  logic [31:0] held;
  int          delay;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic e, input logic [31:0] pc, input logic fl, input logic ak,
                      input logic [31:0] d, input logic er, input logic rd);
    logic exp_issue;
    logic exp_valid;
    en = e; i_pc = pc; i_flush = fl; i_imem_ack = ak;
    i_imem_rdata = d; i_imem_err = er; i_ready = rd;
    #2;
    if (rst) begin
      q.delete();
      outstanding = 1'b0;
      drop = 1'b0;
    end else begin
      exp_issue = e && !outstanding && !fl && (q.size() < DEPTH);
      exp_valid = (q.size() > 0) && !fl;
      chk("valid", {31'b0, o_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("instr_pc", o_instr_pc, q[0].pc);
        chk("instr", o_instr, q[0].instr);
`ifdef IFETCH_PREFETCH_ABORT_EN
        chk("abort", {31'b0, o_abort}, {31'b0, q[0].abort});
`endif
      end
      chk("pc_adv", {31'b0, o_pc_adv}, {31'b0, exp_issue});
      chk("imem_req", {31'b0, o_imem_req}, {31'b0, outstanding || exp_issue});
      if (outstanding) chk("addr_held", o_imem_addr, held);
      else if (exp_issue) chk("addr_issue", o_imem_addr, {pc[31:2], 2'b00});
      if (e) begin
        if (exp_valid && rd) void'(q.pop_front());
        if (fl) q.delete();
        if (outstanding && ak) begin
          if (!fl && !drop) q.push_back('{pc: held, instr: d, abort: er});
          outstanding = 1'b0;
          drop = 1'b0;
        end else if (outstanding && fl) begin
          drop = 1'b1;
        end
        if (exp_issue) begin
          outstanding = 1'b1;
          held = {pc[31:2], 2'b00};
          delay = $urandom_range(0, 3);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ak;
    logic e;
    checks = 0; errors = 0;
    outstanding = 1'b0; drop = 1'b0; held = '0; delay = 0;
    rst = 1'b1;
    en = 1'b1; i_pc = 32'h0000_1230; i_flush = 1'b0; i_imem_ack = 1'b0;
    i_imem_rdata = '0; i_imem_err = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    #2;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_adv", {31'b0, o_pc_adv}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_instr_pc", o_instr_pc, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back fetch of 0x0, 0x4, 0x8 with decode always ready
    step(1, 32'h0,  0, 0, $urandom, 0, 1);
    step(1, 32'h0,  0, 1, $urandom, 0, 1);
    step(1, 32'h4,  0, 0, $urandom, 0, 1);
    step(1, 32'h4,  0, 1, $urandom, 0, 1);
    step(1, 32'h8,  0, 0, $urandom, 0, 1);
    step(1, 32'h8,  0, 1, $urandom, 0, 1);

    // Decode stalls: buffer fills, requests stop until a pop
    step(1, 32'hC,  0, 0, $urandom, 0, 1);
    step(1, 32'hC,  0, 1, $urandom, 0, 0);
    step(1, 32'h10, 0, 0, $urandom, 0, 0);
    step(1, 32'h10, 0, 1, $urandom, 0, 0);
    step(1, 32'h14, 0, 0, $urandom, 0, 0);
    step(1, 32'h14, 0, 0, $urandom, 0, 0);
    step(1, 32'h14, 0, 0, $urandom, 0, 1);
    step(1, 32'h14, 0, 0, $urandom, 0, 0);

    // Flush while waiting; late response must be dropped
    step(1, 32'h100, 1, 0, $urandom, 0, 0);
    step(1, 32'h100, 0, 0, $urandom, 0, 0);
    step(1, 32'h100, 0, 0, $urandom, 0, 0);
    step(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0);
    chk("drain_drop_valid", {31'b0, o_valid}, 32'd0);
    step(1, 32'h100, 0, 0, $urandom, 0, 1);

    // Flush coinciding with ack
    step(1, 32'h104, 1, 1, $urandom, 0, 1);
    chk("flush_ack_valid", {31'b0, o_valid}, 32'd0);
    step(1, 32'h200, 0, 0, $urandom, 0, 0);
    step(1, 32'h200, 0, 1, $urandom, 0, 0);
    step(1, 32'h204, 0, 0, $urandom, 0, 0);

    // Stage disabled mid-stream with a request outstanding
    repeat (4) step(0, 32'h300, 0, 0, $urandom, 0, 0);
    step(1, 32'h204, 0, 1, $urandom, 0, 0);
    step(1, 32'h208, 0, 0, $urandom, 0, 1);
    step(1, 32'h208, 0, 0, $urandom, 0, 1);
    step(1, 32'h208, 0, 1, $urandom, 0, 1);

    // Error response on 0x20
    step(1, 32'h20, 0, 0, $urandom, 0, 1);
    step(1, 32'h20, 0, 1, $urandom, 1, 1);
    step(1, 32'h24, 0, 0, $urandom, 0, 1);
    step(1, 32'h24, 0, 1, $urandom, 0, 1);
    step(1, 32'h28, 0, 0, $urandom, 0, 1);
    step(1, 32'h28, 0, 1, $urandom, 0, 0);
    step(1, 32'h28, 1, 0, $urandom, 0, 0);

    // Reset while a request is outstanding
    step(1, 32'h40, 0, 0, $urandom, 0, 0);
    rst = 1'b1;
    step(1, 32'h40, 0, 0, $urandom, 0, 0);
    rst = 1'b0;
    step(1, 32'h45, 0, 0, $urandom, 0, 0);
    step(1, 32'h45, 0, 1, $urandom, 0, 1);

    // Randomized traffic with random ack latency, stalls, flushes and enable gaps
    for (int n = 0; n < 400; n++) begin
      ak = outstanding && (delay == 0);
      if (outstanding && delay != 0) delay--;
      e = ak ? 1'b1 : ($urandom_range(0, 15) != 0);
      step(e, $urandom, ($urandom_range(0, 15) == 0), ak, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  stage enable; when low, no state changes and no new request issues.
REQ-005 SHALL have port i_pc  input  32  current fetch address from the PC register stage.
REQ-006 SHALL have port i_flush  input  1  redirect (branch, PC write or IRQ); discards all buffered and in-flight instructions.
REQ-007 SHALL have port o_pc_adv  output  1  one-cycle pulse telling the PC stage to advance (drives its en).
REQ-008 SHALL have ports o_imem_req  output  1, o_imem_addr  output  32, i_imem_ack  input  1, i_imem_rdata  input  32  instruction memory handshake.
REQ-009 SHALL have ports o_valid  output  1, o_instr  output  32, o_instr_pc  output  32, i_ready  input  1  decode-side valid/ready handshake.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT (one request outstanding) and DRAIN (outstanding response to be discarded).
REQ-011 IDLE->WAIT SHALL occur when en=1, i_flush=0 and the buffer has at least one free entry; that cycle o_imem_req=1, o_imem_addr={i_pc[31:2],2'b00}, o_pc_adv=1.
REQ-012 At most one request SHALL be outstanding; o_imem_req and o_imem_addr SHALL stay stable in WAIT until i_imem_ack.
REQ-013 WAIT with i_imem_ack=1 and no flush SHALL push {address, i_imem_rdata} into the buffer and return to IDLE; the next request issues no earlier than the following cycle.
REQ-014 i_flush=1 SHALL empty the buffer in the same cycle; in WAIT without ack it SHALL go to DRAIN; if ack coincides, the response SHALL be discarded and the FSM SHALL go to IDLE.
REQ-015 DRAIN SHALL hold o_imem_req=1 and, on i_imem_ack, discard the data and go to IDLE.
REQ-016 o_valid SHALL be 1 iff the buffer is non-empty and i_flush=0; o_instr/o_instr_pc SHALL show the oldest entry; pop on o_valid&i_ready.
REQ-017 Simultaneous push and pop on a full buffer SHALL be accepted; push on a full buffer without pop SHALL not occur because of REQ-011.
REQ-018 Buffer pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.
REQ-019 o_pc_adv SHALL never assert in a cycle where i_flush=1 or en=0.
REQ-020 Fetch-to-o_valid latency SHALL be ack cycle + 1.

Reset
REQ-021 On rst=1 at a clock edge: FSM=IDLE, buffer empty, o_imem_req=0, o_pc_adv=0, o_valid=0, o_instr=0, o_instr_pc=0.
REQ-022 Reset while in WAIT or DRAIN SHALL abandon the request; the memory system is reset with the same signal.

Configuration
REQ-023 Macro IFETCH_PREFETCH_ABORT_EN SHALL add input i_imem_err (valid with i_imem_ack) and output o_abort.
REQ-024 With the macro defined, each entry SHALL carry an abort bit equal to i_imem_err, shown as o_abort with its entry; without it, neither port nor storage SHALL exist, and errors are not signalled.

Structure
REQ-025 FSM state encodings and the 32-bit word-width constant SHALL live in the shared core package.
REQ-026 The buffer SHALL be a separate sub-module ifetch_fifo (synchronous, parameterized width and DEPTH, same clk/rst).

Verification
REQ-027 Reset, then i_pc=0x0, 0x4, 0x8, ack one cycle after each req, i_ready=1 -> o_instr_pc sequence 0x0, 0x4, 0x8 with matching rdata, o_pc_adv one pulse per request.
REQ-028 i_ready=0 with DEPTH=2 -> exactly two requests issue, then o_imem_req stays 0 until a pop, and the next request issues in the cycle after the pop.
REQ-029 i_flush during WAIT, ack 3 cycles later with 0xDEADBEEF -> FSM passes through DRAIN, data dropped, o_valid=0, next request uses new i_pc=0x100.
REQ-030 i_flush and i_imem_ack in the same cycle -> no push, FSM=IDLE next cycle, buffer empty.
REQ-031 en=0 for 4 cycles mid-stream -> no state change, o_pc_adv=0, outputs held.
REQ-032 With IFETCH_PREFETCH_ABORT_EN defined, i_imem_err=1 on the ack for 0x20 -> o_abort=1 only with o_instr_pc=0x20.
